// File: rtl/ir_fetch_ctrl.sv
// ir_fetch_ctrl: two-byte instruction fetch sequencer.
// Reads lo/hi bytes from memory and writes them into the IR register.
module ir_fetch_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Abort,
  input  logic [15:0] PCIn,
  input  logic [7:0]  MemData,
  input  logic        MemReady,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  output logic        RegE,
  output logic [2:0]  RegFunSel,
  output logic [15:0] RegI,
  output logic        PCInc,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] IROut
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, WR_LO, RD_HI, WR_HI, DONE, ERR
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state, next;
  logic [15:0] addr;
  logic [7:0]  lo, hi;
  logic [15:0] ir;
  logic [7:0]  cnt;
  logic        rd;

  assign rd = (state == RD_LO) || (state == RD_HI);

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (Start) next = RD_LO;
      RD_LO: begin
        if (Abort)              next = IDLE;
        else if (MemReady)      next = WR_LO;
        else if (cnt == TLAST)  next = ERR;
      end
      WR_LO: next = Abort ? IDLE : RD_HI;
      RD_HI: begin
        if (Abort)              next = IDLE;
        else if (MemReady)      next = WR_HI;
        else if (cnt == TLAST)  next = ERR;
      end
      WR_HI: next = Abort ? IDLE : DONE;
      DONE:  next = IDLE;
      ERR:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  // cnt tracks consecutive MemReady-low cycles; cleared on any state change
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      addr  <= '0;
      lo    <= '0;
      hi    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= next;
      if (next != state)
        cnt <= '0;
      else if (rd && !MemReady)
        cnt <= cnt + 8'd1;
      if (state == IDLE && Start)
        addr <= PCIn;
      if (state == RD_LO && MemReady && !Abort)
        lo <= MemData;
      if (state == RD_HI && MemReady && !Abort)
        hi <= MemData;
      if (state == WR_HI && !Abort)
        ir <= {hi, lo};
    end
  end

  always_comb begin
    MemAddr   = addr;
    MemRead   = 1'b0;
    RegE      = 1'b0;
    RegFunSel = 3'b000;
    RegI      = 16'h0000;
    PCInc     = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Err       = 1'b0;
    unique case (state)
      IDLE: ;
      RD_LO: begin
        MemRead = 1'b1;
        Busy    = 1'b1;
      end
      WR_LO: begin
        Busy = 1'b1;
        if (!Abort) begin
          RegE      = 1'b1;
          RegFunSel = 3'b101;
          RegI      = {8'h00, lo};
          PCInc     = 1'b1;
        end
      end
      RD_HI: begin
        MemRead = 1'b1;
        MemAddr = addr + 16'd1;
        Busy    = 1'b1;
      end
      WR_HI: begin
        Busy = 1'b1;
        if (!Abort) begin
          RegE      = 1'b1;
          RegFunSel = 3'b110;
          RegI      = {8'h00, hi};
          PCInc     = 1'b1;
        end
      end
      DONE: Done = 1'b1;
      ERR:  Err  = 1'b1;
      default: ;
    endcase
  end

  assign IROut = ir;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// tb_ir_fetch_ctrl: vector table, random fetches and reset sequences
// checked against a timeline model of each fetch.
module tb_ir_fetch_ctrl;

  localparam int TO = 16;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Abort;
  logic [15:0] PCIn;
  logic [7:0]  MemData;
  logic        MemReady;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        RegE;
  logic [2:0]  RegFunSel;
  logic [15:0] RegI;
  logic        PCInc;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [15:0] IROut;

  ir_fetch_ctrl #(.TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
    .PCIn(PCIn), .MemData(MemData), .MemReady(MemReady),
    .MemAddr(MemAddr), .MemRead(MemRead), .RegE(RegE),
    .RegFunSel(RegFunSel), .RegI(RegI), .PCInc(PCInc),
    .Busy(Busy), .Done(Done), .Err(Err), .IROut(IROut)
  );

  always #5 Clock = ~Clock;

  typedef enum {P_IDLE, P_RDLO, P_WRLO, P_RDHI, P_WRHI, P_DONE, P_ERR} ph_t;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          wlo;
    int          whi;
    int          ab;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] addr_exp = 16'h0000;
  logic [15:0] ir_exp = 16'h0000;

  function automatic logic [56:0] pack(
    input logic [15:0] ma, input logic mr, re,
    input logic [2:0] fs, input logic [15:0] ri,
    input logic pi, bz, dn, er, input logic [15:0] ir);
    return {ma, mr, re, fs, ri, pi, bz, dn, er, ir};
  endfunction

  function automatic logic [56:0] actual();
    return pack(MemAddr, MemRead, RegE, RegFunSel, RegI,
                PCInc, Busy, Done, Err, IROut);
  endfunction

  // cycle t (1 = first cycle after the Start edge) of a fetch
  // whose low byte waits wlo cycles and high byte waits whi cycles
  function automatic ph_t phase_at(input int t, input int wlo, input int whi);
    int hs;
    if (wlo >= TO)
      return (t <= TO) ? P_RDLO : ((t == TO + 1) ? P_ERR : P_IDLE);
    if (t <= wlo + 1) return P_RDLO;
    if (t == wlo + 2) return P_WRLO;
    hs = wlo + 3;
    if (whi >= TO)
      return (t < hs + TO) ? P_RDHI : ((t == hs + TO) ? P_ERR : P_IDLE);
    if (t <= hs + whi) return P_RDHI;
    if (t == hs + whi + 1) return P_WRHI;
    if (t == hs + whi + 2) return P_DONE;
    return P_IDLE;
  endfunction

  function automatic logic [56:0] expect_out(
    input ph_t ph, input bit abt, input logic [15:0] pc,
    input logic [7:0] lo, hi);
    logic [15:0] pc1;
    pc1 = pc + 16'd1;
    case (ph)
      P_RDLO: return pack(pc, 1, 0, 0, 0, 0, 1, 0, 0, ir_exp);
      P_RDHI: return pack(pc1, 1, 0, 0, 0, 0, 1, 0, 0, ir_exp);
      P_WRLO: return abt ? pack(pc, 0, 0, 0, 0, 0, 1, 0, 0, ir_exp)
                         : pack(pc, 0, 1, 3'b101, {8'h00, lo}, 1, 1, 0, 0, ir_exp);
      P_WRHI: return abt ? pack(pc, 0, 0, 0, 0, 0, 1, 0, 0, ir_exp)
                         : pack(pc, 0, 1, 3'b110, {8'h00, hi}, 1, 1, 0, 0, ir_exp);
      P_DONE: return pack(pc, 0, 0, 0, 0, 0, 0, 1, 0, ir_exp);
      P_ERR:  return pack(pc, 0, 0, 0, 0, 0, 0, 0, 1, ir_exp);
      default: return pack(addr_exp, 0, 0, 0, 0, 0, 0, 0, 0, ir_exp);
    endcase
  endfunction

  task automatic check(input string name, input logic [56:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // called just after a posedge with the DUT idle
  task automatic run_fetch(input string name, input logic [15:0] pc,
                           input logic [7:0] lo, hi,
                           input int wlo, whi, ab, input bit rnd);
    ph_t ph;
    bit  abt;
    bit  stop;
    Start    = 1'b1;
    PCIn     = pc;
    Abort    = rnd ? 1'($urandom) : 1'b0;
    MemReady = rnd ? 1'($urandom) : 1'b0;
    MemData  = 8'($urandom);
    @(negedge Clock);
    check($sformatf("%s c0", name), actual(),
          expect_out(P_IDLE, 0, pc, lo, hi));
    @(posedge Clock); #1;
    addr_exp = pc;
    stop = 0;
    for (int t = 1; t < 200 && !stop; t++) begin
      ph = phase_at(t, wlo, whi);
      if (ph == P_IDLE) begin
        stop = 1;
      end else begin
        abt      = (ab == t);
        Start    = rnd ? 1'($urandom) : 1'b0;
        PCIn     = rnd ? 16'($urandom) : pc;
        Abort    = abt;
        MemData  = 8'($urandom);
        if (ph == P_RDLO) begin
          MemReady = (t == wlo + 1);
          if (MemReady) MemData = lo;
        end else if (ph == P_RDHI) begin
          MemReady = (t == wlo + 3 + whi);
          if (MemReady) MemData = hi;
        end else begin
          MemReady = rnd ? 1'($urandom) : 1'b0;
        end
        @(negedge Clock);
        check($sformatf("%s c%0d", name, t), actual(),
              expect_out(ph, abt, pc, lo, hi));
        if (ph == P_WRHI && !abt) ir_exp = {hi, lo};
        @(posedge Clock); #1;
        if (abt) stop = 1;
      end
    end
    Start    = 1'b0;
    Abort    = 1'b0;
    MemReady = rnd ? 1'($urandom) : 1'b0;
    PCIn     = 16'($urandom);
    @(negedge Clock);
    check($sformatf("%s end", name), actual(),
          expect_out(P_IDLE, 0, pc, lo, hi));
    @(posedge Clock); #1;
  endtask

  vec_t vecs[8];

  initial begin
    int wlo, whi, ab, len;

    vecs[0] = '{"basic",    16'h0040, 8'h3C, 8'hA5, 0, 0, 0};
    vecs[1] = '{"wrap",     16'hFFFF, 8'h12, 8'h34, 0, 0, 0};
    vecs[2] = '{"hiwait3",  16'h2000, 8'h5A, 8'hC3, 0, 3, 0};
    vecs[3] = '{"lotmo",    16'h3000, 8'hDE, 8'hAD, TO, 0, 0};
    vecs[4] = '{"abwrhi",   16'h4000, 8'h99, 8'h66, 0, 0, 4};
    vecs[5] = '{"hitmo",    16'h5000, 8'h01, 8'h02, 1, TO, 0};
    vecs[6] = '{"lo_edge",  16'h6000, 8'hF0, 8'h0F, TO - 1, 2, 0};
    vecs[7] = '{"abrdlo",   16'h7000, 8'h44, 8'h55, 5, 0, 3};

    Reset    = 1'b0;
    Start    = 1'b0;
    Abort    = 1'b0;
    PCIn     = 16'h0000;
    MemData  = 8'h00;
    MemReady = 1'b0;
    #1;
    check("reset_now", actual(), '0);
    @(posedge Clock);
    @(negedge Clock);
    check("reset_hold", actual(), '0);
    @(posedge Clock); #1;
    Reset = 1'b1;

    foreach (vecs[i])
      run_fetch(vecs[i].name, vecs[i].pc, vecs[i].lo, vecs[i].hi,
                vecs[i].wlo, vecs[i].whi, vecs[i].ab, 1'b0);

    for (int n = 0; n < 40; n++) begin
      wlo = ($urandom % 8 == 0) ? TO + int'($urandom % 3) : int'($urandom % 4);
      whi = ($urandom % 8 == 0) ? TO + int'($urandom % 3) : int'($urandom % 4);
      if (wlo >= TO)      len = TO;
      else if (whi >= TO) len = wlo + 2 + TO;
      else                len = wlo + whi + 4;
      ab = ($urandom % 5 == 0) ? 1 + int'($urandom % len) : 0;
      run_fetch($sformatf("rnd%0d", n), 16'($urandom), 8'($urandom),
                8'($urandom), wlo, whi, ab, 1'b1);
    end

    // reset pulse in the middle of RD_HI
    Start = 1'b1; PCIn = 16'h1234; Abort = 1'b0; MemReady = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0; MemReady = 1'b1; MemData = 8'h11;
    @(posedge Clock); #1;
    MemReady = 1'b0;
    @(posedge Clock); #1;
    @(negedge Clock);
    check("mid_rdhi", actual(),
          pack(16'h1235, 1, 0, 0, 0, 0, 1, 0, 0, ir_exp));
    #2 Reset = 1'b0;
    #1 check("rst_async", actual(), '0);
    @(posedge Clock);
    @(negedge Clock);
    check("rst_low", actual(), '0);
    @(posedge Clock); #1;
    Reset    = 1'b1;
    addr_exp = 16'h0000;
    ir_exp   = 16'h0000;
    run_fetch("post_rst", 16'h0100, 8'h77, 8'h88, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
